// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared widths, the pad byte and the assembler state encoding used by the
// host byte-to-word path feeding the coordinator's decompression input.
// ---------------------------------------------------------------------------
package io_pkg;

  localparam int                BYTE_W   = 8;
  localparam int                WORD_W   = 16;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

  // HI: waiting for the high byte of a word; LO: high byte held, waiting for low.
  typedef enum logic {
    ASM_HI = 1'b0,
    ASM_LO = 1'b1
  } asmState_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO: the head entry is always present
// on popData while empty is low. Pointers are AW bits wide and wrap naturally
// because DEPTH is a power of two.
//
// Ports:
//   clk       system clock, rising edge
//   RST       asynchronous, active-low reset (pointers and count only)
//   push      write pushData (ignored when full)
//   pushData  word to write
//   pop       drop the head entry (ignored when empty)
//   popData   head entry
//   count     entries currently stored, 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
// ---------------------------------------------------------------------------
module sync_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates visibility of every
  // entry, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/io_word_assembler.sv
// ---------------------------------------------------------------------------
// io_word_assembler
// Packs host bytes into 16-bit words (first byte -> [15:8], second -> [7:0]),
// buffers them in a FWFT FIFO and presents them on a valid/ready interface
// driving the coordinator's Din. A byte flagged host_last in HI is padded to
// {byte, 8'h00}. interrupt requests service when the fill level reaches
// THRESH or when a frame has ended and words remain buffered.
//
// Optional build macro: IO_PARITY_EN
//   defined   - bytes failing even parity are handshaken but dropped and set
//               the sticky parity_err (cleared by clr_err, set wins)
//   undefined - host_parity and clr_err ignored, parity_err tied 0
//
// Ports:
//   clk, RST                 clock / asynchronous active-low reset
//   host_valid, host_byte,
//   host_last, host_parity   host byte stream in
//   host_ready               byte accepted this cycle when host_valid high
//   word_valid, word_data    FIFO head toward the coordinator
//   word_ready               consumer pops the head
//   fill_level               words currently stored
//   interrupt                registered service request
//   parity_err, clr_err      sticky parity error and its clear
// ---------------------------------------------------------------------------
module io_word_assembler
  import io_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              host_valid,
  input  logic [BYTE_W-1:0] host_byte,
  input  logic              host_last,
  input  logic              host_parity,
  output logic              host_ready,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  input  logic              word_ready,
  output logic [AW:0]       fill_level,
  output logic              interrupt,
  output logic              parity_err,
  input  logic              clr_err
);

  localparam logic [AW:0] THRESH_LVL = (AW+1)'(THRESH);

  asmState_t         state;
  asmState_t         stateNext;
  logic [BYTE_W-1:0] hold;
  logic [BYTE_W-1:0] holdNext;
  logic [WORD_W-1:0] pushWord;
  logic [AW:0]       nextCount;
  logic              frameEnd;
  logic              frameEndNext;
  logic              interruptNext;
  logic              accept;
  logic              badByte;
  logic              errSet;
  logic              pushReq;
  logic              popReq;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              drain;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uFifo (
    .clk      (clk),
    .RST      (RST),
    .push     (pushReq),
    .pushData (pushWord),
    .pop      (popReq),
    .popData  (word_data),
    .count    (fill_level),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Gated by RST so the host sees no ready while reset is held.
  assign host_ready = RST && !fifoFull;
  assign word_valid = !fifoEmpty;
  assign accept     = host_valid && host_ready;
  assign popReq     = word_valid && word_ready;

`ifdef IO_PARITY_EN
  assign badByte = ^{host_byte, host_parity};
`else
  assign badByte = 1'b0;
`endif

  // NOTE: every output of this block gets a default before any branch so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    holdNext  = hold;
    pushReq   = 1'b0;
    pushWord  = '0;
    errSet    = 1'b0;
    if (accept) begin
      if (badByte) begin
        // Dropped byte; a frame end still flushes any held high byte.
        errSet = 1'b1;
        if (host_last && state == ASM_LO) begin
          pushReq   = 1'b1;
          pushWord  = {hold, PAD_BYTE};
          stateNext = ASM_HI;
        end
      end else if (state == ASM_HI) begin
        if (host_last) begin
          pushReq  = 1'b1;
          pushWord = {host_byte, PAD_BYTE};
        end else begin
          holdNext  = host_byte;
          stateNext = ASM_LO;
        end
      end else begin
        pushReq   = 1'b1;
        pushWord  = {hold, host_byte};
        stateNext = ASM_HI;
      end
    end
  end

  // Last old word leaving; a coinciding push's host_last overrides the clear.
  assign drain        = popReq && (fill_level == (AW+1)'(1));
  assign frameEndNext = (accept && host_last) ? 1'b1 : (drain ? 1'b0 : frameEnd);
  assign nextCount    = fill_level + (AW+1)'(pushReq) - (AW+1)'(popReq);
  assign interruptNext = (nextCount >= THRESH_LVL) ||
                         (frameEndNext && nextCount != '0);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= ASM_HI;
      hold      <= '0;
      frameEnd  <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      state     <= stateNext;
      hold      <= holdNext;
      frameEnd  <= frameEndNext;
      interrupt <= interruptNext;
    end
  end

`ifdef IO_PARITY_EN
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)         parity_err <= 1'b0;
    else if (errSet)  parity_err <= 1'b1;
    else if (clr_err) parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
  logic unusedParity;
  assign unusedParity = ^{host_parity, clr_err, errSet};
`endif

endmodule

// File: tb/tb_io_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_io_word_assembler
// Scenario tasks drive io_word_assembler and compare its outputs against a
// queue-based reference model of the byte-pairing, FIFO, frame-end and
// interrupt rules. Build with +define+IO_PARITY_EN to include the parity case.
// ---------------------------------------------------------------------------
module tb_io_word_assembler;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int THRESH = 8;

  logic        clk;
  logic        RST;
  logic        host_valid;
  logic [7:0]  host_byte;
  logic        host_last;
  logic        host_parity;
  logic        host_ready;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;
  logic [AW:0] fill_level;
  logic        interrupt;
  logic        parity_err;
  logic        clr_err;

  io_word_assembler #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .THRESH (THRESH)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .host_valid  (host_valid),
    .host_byte   (host_byte),
    .host_last   (host_last),
    .host_parity (host_parity),
    .host_ready  (host_ready),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .fill_level  (fill_level),
    .interrupt   (interrupt),
    .parity_err  (parity_err),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  logic [15:0] mQ[$];
  bit          mHasHi;
  logic [7:0]  mHi;
  bit          mFrameEnd;
  bit          mIrq;
  bit          mParErr;

  task automatic model_reset();
    mQ.delete();
    mHasHi    = 1'b0;
    mHi       = 8'h00;
    mFrameEnd = 1'b0;
    mIrq      = 1'b0;
    mParErr   = 1'b0;
  endtask

  function automatic bit bad_parity(input logic [7:0] b, input logic p);
`ifdef IO_PARITY_EN
    return ^{b, p};
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic pick_parity(input logic [7:0] b);
`ifdef IO_PARITY_EN
    return ($urandom_range(9) == 0) ? ~(^b) : ^b;
`else
    return 1'($urandom_range(1));
`endif
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, and return
  // at edge+1 with DUT outputs settled.
  task automatic drive_cycle(input logic v, input logic [7:0] b, input logic l,
                             input logic p, input logic r, input logic c,
                             output bit accepted);
    int cnt;
    bit pop;
    bit drain;
    bit errSet;
    host_valid  = v;
    host_byte   = b;
    host_last   = l;
    host_parity = p;
    word_ready  = r;
    clr_err     = c;
    cnt      = mQ.size();
    accepted = v && (cnt < DEPTH);
    pop      = (cnt != 0) && r;
    drain    = pop && (cnt == 1);
    errSet   = accepted && bad_parity(b, p);
    @(posedge clk);
    if (pop) void'(mQ.pop_front());
    if (accepted) begin
      if (errSet) begin
        if (l && mHasHi) begin
          mQ.push_back({mHi, 8'h00});
          mHasHi = 1'b0;
        end
      end else if (mHasHi) begin
        mQ.push_back({mHi, b});
        mHasHi = 1'b0;
      end else if (l) begin
        mQ.push_back({b, 8'h00});
      end else begin
        mHi    = b;
        mHasHi = 1'b1;
      end
    end
    if (accepted && l) mFrameEnd = 1'b1;
    else if (drain)    mFrameEnd = 1'b0;
    mIrq = (mQ.size() >= THRESH) || (mFrameEnd && mQ.size() != 0);
    if (errSet)  mParErr = 1'b1;
    else if (c)  mParErr = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    word_ready = 1'b0;
    clr_err    = 1'b0;
    #2 RST = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) RST = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    host_valid = 1'b0;
    word_ready = 1'b0;
    clr_err    = 1'b0;
    #2 RST = 1'b0;
    #1;
    testsRun++;
    if (host_ready !== 1'b0) begin testsFailed++; $display("FAIL reset_host_ready: got %b want 0", host_ready); end
    testsRun++;
    if (word_valid !== 1'b0) begin testsFailed++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    testsRun++;
    if (fill_level !== '0) begin testsFailed++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    testsRun++;
    if (interrupt !== 1'b0) begin testsFailed++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
    testsRun++;
    if (parity_err !== 1'b0) begin testsFailed++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    repeat (2) @(posedge clk);
    @(negedge clk) RST = 1'b1;
    model_reset();
    @(posedge clk); #1;
    testsRun++;
    if (host_ready !== 1'b1) begin testsFailed++; $display("FAIL post_reset_ready: got %b want 1", host_ready); end
  endtask

  task automatic test_pack();
    logic [7:0] bytes [4] = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    bit acc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, bytes[i], 1'b0, ^bytes[i], 1'b0, 1'b0, acc);
      if (i == 1) begin
        testsRun++;
        if (word_valid !== 1'b1) begin testsFailed++; $display("FAIL pack_latency: word_valid got %b want 1", word_valid); end
      end
    end
    testsRun++;
    if (word_data !== 16'hABCD) begin testsFailed++; $display("FAIL pack_data: got %h want abcd", word_data); end
    testsRun++;
    if (fill_level !== 5'd2) begin testsFailed++; $display("FAIL pack_fill: got %0d want 2", fill_level); end
    testsRun++;
    if (host_ready !== 1'b1) begin testsFailed++; $display("FAIL pack_ready: got %b want 1", host_ready); end
    testsRun++;
    if (interrupt !== 1'b0) begin testsFailed++; $display("FAIL pack_irq: got %b want 0", interrupt); end
  endtask

  task automatic test_frame_end();
    bit acc;
    do_reset();
    drive_cycle(1'b1, 8'h11, 1'b0, ^8'h11, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h22, 1'b0, ^8'h22, 1'b0, 1'b0, acc);
    testsRun++;
    if (interrupt !== 1'b0) begin testsFailed++; $display("FAIL frame_irq_mid: got %b want 0", interrupt); end
    drive_cycle(1'b1, 8'h33, 1'b1, ^8'h33, 1'b0, 1'b0, acc);
    testsRun++;
    if (word_data !== 16'h1122) begin testsFailed++; $display("FAIL frame_word0: got %h want 1122", word_data); end
    testsRun++;
    if (interrupt !== 1'b1) begin testsFailed++; $display("FAIL frame_irq_set: got %b want 1", interrupt); end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    testsRun++;
    if (word_data !== 16'h3300) begin testsFailed++; $display("FAIL frame_word1: got %h want 3300", word_data); end
    testsRun++;
    if (interrupt !== 1'b1) begin testsFailed++; $display("FAIL frame_irq_hold: got %b want 1", interrupt); end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    testsRun++;
    if (word_valid !== 1'b0) begin testsFailed++; $display("FAIL frame_empty: word_valid got %b want 0", word_valid); end
    testsRun++;
    if (interrupt !== 1'b0) begin testsFailed++; $display("FAIL frame_irq_clr: got %b want 0", interrupt); end
  endtask

  task automatic test_full_stall();
    logic [7:0] bytes [34];
    bit acc;
    bit done;
    for (int i = 0; i < 34; i++) bytes[i] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive_cycle(1'b1, bytes[i], 1'b0, ^bytes[i], 1'b0, 1'b0, acc);
      testsRun++;
      if (fill_level !== (AW+1)'(i/2 + i%2 * 0 + (i%2))) begin
        testsFailed++; $display("FAIL stall_fill_%0d: got %0d want %0d", i, fill_level, (i+1)/2);
      end
      testsRun++;
      if (interrupt !== ((i+1)/2 >= THRESH)) begin
        testsFailed++; $display("FAIL stall_irq_%0d: got %b want %b", i, interrupt, ((i+1)/2 >= THRESH));
      end
    end
    testsRun++;
    if (host_ready !== 1'b0) begin testsFailed++; $display("FAIL stall_full_ready: got %b want 0", host_ready); end
    drive_cycle(1'b1, bytes[32], 1'b0, ^bytes[32], 1'b0, 1'b0, acc);
    testsRun++;
    if (fill_level !== 5'd16) begin testsFailed++; $display("FAIL stall_hold_fill: got %0d want 16", fill_level); end
    testsRun++;
    if (word_data !== {bytes[0], bytes[1]}) begin
      testsFailed++; $display("FAIL stall_head: got %h want %h", word_data, {bytes[0], bytes[1]});
    end
    drive_cycle(1'b1, bytes[32], 1'b0, ^bytes[32], 1'b1, 1'b0, acc);
    done = 1'b0;
    for (int t = 0; t < 4 && !done; t++) begin
      drive_cycle(1'b1, bytes[32], 1'b0, ^bytes[32], 1'b0, 1'b0, acc);
      done = acc;
    end
    testsRun++;
    if (!done) begin testsFailed++; $display("FAIL stall_resume: stalled byte accepted got 0 want 1"); end
    drive_cycle(1'b1, bytes[33], 1'b0, ^bytes[33], 1'b0, 1'b0, acc);
    for (int k = 1; k < 17; k++) begin
      testsRun++;
      if (word_valid !== 1'b1 || word_data !== {bytes[2*k], bytes[2*k+1]}) begin
        testsFailed++;
        $display("FAIL stall_seq_%0d: got %b/%h want 1/%h", k, word_valid, word_data, {bytes[2*k], bytes[2*k+1]});
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    end
    testsRun++;
    if (fill_level !== '0) begin testsFailed++; $display("FAIL stall_drained: got %0d want 0", fill_level); end
  endtask

  task automatic test_reset_mid();
    bit acc;
    do_reset();
    drive_cycle(1'b1, 8'h55, 1'b0, ^8'h55, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h66, 1'b0, ^8'h66, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h7E, 1'b0, ^8'h7E, 1'b0, 1'b0, acc);
    host_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    testsRun++;
    if (word_valid !== 1'b0) begin testsFailed++; $display("FAIL midreset_valid: got %b want 0", word_valid); end
    testsRun++;
    if (fill_level !== '0) begin testsFailed++; $display("FAIL midreset_fill: got %0d want 0", fill_level); end
    testsRun++;
    if (host_ready !== 1'b0) begin testsFailed++; $display("FAIL midreset_ready: got %b want 0", host_ready); end
    @(negedge clk) RST = 1'b1;
    model_reset();
    drive_cycle(1'b1, 8'h01, 1'b0, ^8'h01, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h02, 1'b0, ^8'h02, 1'b0, 1'b0, acc);
    testsRun++;
    if (word_data !== 16'h0102 || fill_level !== 5'd1) begin
      testsFailed++; $display("FAIL midreset_word: got %h/%0d want 0102/1", word_data, fill_level);
    end
  endtask

  task automatic run_traffic(input int n, input bit toggleReady, input string tag);
    bit acc;
    logic [7:0] b;
    logic v, l, p, r, c;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (toggleReady) begin
        v = 1'b1; l = 1'b0; r = i[0]; c = 1'b0;
      end else begin
        v = ($urandom_range(9) < 7);
        l = ($urandom_range(9) == 0);
        r = ($urandom_range(9) < 6);
        c = ($urandom_range(19) == 0);
      end
      p = pick_parity(b);
      drive_cycle(v, b, l, p, r, c, acc);
      testsRun++;
      if (fill_level !== (AW+1)'(mQ.size())) begin
        testsFailed++; $display("FAIL %s_fill@%0d: got %0d want %0d", tag, i, fill_level, mQ.size());
      end
      testsRun++;
      if (host_ready !== (mQ.size() < DEPTH)) begin
        testsFailed++; $display("FAIL %s_ready@%0d: got %b want %b", tag, i, host_ready, (mQ.size() < DEPTH));
      end
      testsRun++;
      if (word_valid !== (mQ.size() != 0)) begin
        testsFailed++; $display("FAIL %s_valid@%0d: got %b want %b", tag, i, word_valid, (mQ.size() != 0));
      end
      if (mQ.size() != 0) begin
        testsRun++;
        if (word_data !== mQ[0]) begin
          testsFailed++; $display("FAIL %s_data@%0d: got %h want %h", tag, i, word_data, mQ[0]);
        end
      end
      testsRun++;
      if (interrupt !== mIrq) begin
        testsFailed++; $display("FAIL %s_irq@%0d: got %b want %b", tag, i, interrupt, mIrq);
      end
      testsRun++;
      if (parity_err !== mParErr) begin
        testsFailed++; $display("FAIL %s_perr@%0d: got %b want %b", tag, i, parity_err, mParErr);
      end
      if (toggleReady) begin
        testsRun++;
        if (fill_level < (AW+1)'(DEPTH-1)) begin
          testsFailed++; $display("FAIL %s_steady@%0d: got %0d want >= %0d", tag, i, fill_level, DEPTH-1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 2*DEPTH; i++) begin
      b = 8'($urandom);
      drive_cycle(1'b1, b, 1'b0, ^b, 1'b0, 1'b0, acc);
    end
    run_traffic(120, 1'b1, "b2b");
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(500, 1'b0, "rand");
  endtask

`ifdef IO_PARITY_EN
  task automatic test_parity();
    bit acc;
    do_reset();
    drive_cycle(1'b1, 8'hA0, 1'b0, ^8'hA0, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'h0B, 1'b0, ^8'h0B, 1'b0, 1'b0, acc);
    testsRun++;
    if (word_data !== 16'hA00B || fill_level !== 5'd1) begin
      testsFailed++; $display("FAIL parity_word: got %h/%0d want a00b/1", word_data, fill_level);
    end
    testsRun++;
    if (parity_err !== 1'b1) begin testsFailed++; $display("FAIL parity_set: got %b want 1", parity_err); end
    drive_cycle(1'b1, 8'hA5, 1'b0, ^8'hA5, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    testsRun++;
    if (parity_err !== 1'b1) begin testsFailed++; $display("FAIL parity_set_wins: got %b want 1", parity_err); end
    testsRun++;
    if (fill_level !== 5'd2 || interrupt !== 1'b1) begin
      testsFailed++; $display("FAIL parity_last_pad: got %0d/%b want 2/1", fill_level, interrupt);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    testsRun++;
    if (word_data !== 16'hA500) begin testsFailed++; $display("FAIL parity_pad_word: got %h want a500", word_data); end
    testsRun++;
    if (parity_err !== 1'b0) begin testsFailed++; $display("FAIL parity_clr: got %b want 0", parity_err); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST         = 1'b0;
    host_valid  = 1'b0;
    host_byte   = 8'h00;
    host_last   = 1'b0;
    host_parity = 1'b0;
    word_ready  = 1'b0;
    clr_err     = 1'b0;
    model_reset();
    @(posedge clk);
    test_reset();
    test_pack();
    test_frame_end();
    test_full_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef IO_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
